// File: rtl/shift_pkg.sv
// Shared operation codes and pipeline-geometry helpers for the barrel shifter.
package shift_pkg;

    typedef enum logic [2:0] {
        SHIFT_SLL = 3'd0,
        SHIFT_SRL = 3'd1,
        SHIFT_SRA = 3'd2,
        SHIFT_ROL = 3'd3,
        SHIFT_ROR = 3'd4
    } shift_op_t;

    function automatic int num_groups(input int shamt_w, input int reg_every);
        return (shamt_w + reg_every - 1) / reg_every;
    endfunction

    // Register stages between input and output transfer, i.e. the latency in cycles.
    function automatic int num_regs(input int shamt_w, input int reg_every, input bit out_reg);
        return num_groups(shamt_w, reg_every) - 1 + (out_reg ? 1 : 0);
    endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Streaming shift-unit bus: request side (op, amount, operand, tag) and result side.
interface shift_pipe_if #(
    parameter int WIDTH   = 64,
    parameter int TAG_W   = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [2:0]         op_i;
    logic [SHAMT_W-1:0] shift_i;
    logic [WIDTH-1:0]   data_i;
    logic [TAG_W-1:0]   tag_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [WIDTH-1:0]   data_o;
    logic [TAG_W-1:0]   tag_o;

    modport master (
        output in_valid_i, op_i, shift_i, data_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, tag_o
    );

    modport slave (
        input  in_valid_i, op_i, shift_i, data_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, tag_o
    );
endinterface

// File: rtl/shift_stage.sv
// One group of NLVL mux levels starting at level BASE, optionally followed by a
// valid/ready register that loads whenever it is empty or its content leaves.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int TAG_W      = 4,
    parameter int SHAMT_W    = $clog2(WIDTH),
    parameter int BASE       = 0,
    parameter int NLVL       = 2,
    parameter bit REGISTERED = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_vld,
    output logic               o_rdy,
    input  logic [2:0]         i_op,
    input  logic [SHAMT_W-1:0] i_sh,
    input  logic               i_sgn,
    input  logic [WIDTH-1:0]   i_dat,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_vld,
    input  logic               i_rdy,
    output logic [2:0]         o_op,
    output logic [SHAMT_W-1:0] o_sh,
    output logic               o_sgn,
    output logic [WIDTH-1:0]   o_dat,
    output logic [TAG_W-1:0]   o_tag
);

    // Moves d by a (a power of two below WIDTH); SRA fills with the carried sign.
    function automatic logic [WIDTH-1:0] level(input logic [WIDTH-1:0] d, input logic [2:0] op,
                                               input logic sgn, input int a);
        logic [WIDTH-1:0] ones;
        ones = '1;
        case (op)
            SHIFT_SLL: return d << a;
            SHIFT_SRL: return d >> a;
            SHIFT_SRA: return (d >> a) | (sgn ? ~(ones >> a) : '0);
            SHIFT_ROL: return (d << a) | (d >> (WIDTH - a));
            SHIFT_ROR: return (d >> a) | (d << (WIDTH - a));
            default:   return d;
        endcase
    endfunction

    logic [WIDTH-1:0] w_dat;

    always_comb begin
        w_dat = i_dat;
        for (int k = 0; k < NLVL; k++) begin
            if (i_sh[BASE+k]) w_dat = level(w_dat, i_op, i_sgn, 1 << (BASE + k));
        end
    end

    if (REGISTERED) begin : g_reg
        logic               r_vld;
        logic [2:0]         r_op;
        logic [SHAMT_W-1:0] r_sh;
        logic               r_sgn;
        logic [WIDTH-1:0]   r_dat;
        logic [TAG_W-1:0]   r_tag;

        assign o_rdy = !r_vld || i_rdy;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_vld <= 1'b0;
                r_op  <= SHIFT_SLL;
                r_sh  <= '0;
                r_sgn <= 1'b0;
                r_dat <= '0;
                r_tag <= '0;
            end else if (o_rdy) begin
                r_vld <= i_vld;
                if (i_vld) begin
                    r_op  <= i_op;
                    r_sh  <= i_sh;
                    r_sgn <= i_sgn;
                    r_dat <= w_dat;
                    r_tag <= i_tag;
                end
            end
        end

        assign o_vld = r_vld;
        assign o_op  = r_op;
        assign o_sh  = r_sh;
        assign o_sgn = r_sgn;
        assign o_dat = r_dat;
        assign o_tag = r_tag;
    end else begin : g_comb
        assign o_rdy = i_rdy;
        assign o_vld = i_vld;
        assign o_op  = i_op;
        assign o_sh  = i_sh;
        assign o_sgn = i_sgn;
        assign o_dat = w_dat;
        assign o_tag = i_tag;
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR), latency num_regs() cycles, 1 op/clk.
// Stalls collapse bubbles stage by stage; in_ready_o follows out_ready_i combinationally.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int REG_EVERY = 2,
    parameter bit OUT_REG   = 1'b1,
    parameter int TAG_W     = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    shift_pipe_if.slave  bus
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int NGRP    = num_groups(SHAMT_W, REG_EVERY);
    localparam int LAT     = num_regs(SHAMT_W, REG_EVERY, OUT_REG);

    logic               w_vld [0:NGRP];
    logic               w_rdy [0:NGRP];
    logic [2:0]         w_op  [0:NGRP];
    logic [SHAMT_W-1:0] w_sh  [0:NGRP];
    logic               w_sgn [0:NGRP];
    logic [WIDTH-1:0]   w_dat [0:NGRP];
    logic [TAG_W-1:0]   w_tag [0:NGRP];

    // Undefined op codes enter as zero data so every level keeps them zero.
    assign w_vld[0] = bus.in_valid_i && !rst_i;
    assign w_op[0]  = bus.op_i;
    assign w_sh[0]  = bus.shift_i;
    assign w_dat[0] = (bus.op_i <= SHIFT_ROR) ? bus.data_i : '0;
    assign w_sgn[0] = w_dat[0][WIDTH-1];
    assign w_tag[0] = bus.tag_i;
    assign w_rdy[NGRP] = bus.out_ready_i;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        localparam int BASE = g * REG_EVERY;
        localparam int NLVL = (SHAMT_W - BASE < REG_EVERY) ? (SHAMT_W - BASE) : REG_EVERY;
        localparam bit REGD = (g < NGRP - 1) || OUT_REG;

        shift_stage #(
            .WIDTH(WIDTH), .TAG_W(TAG_W), .SHAMT_W(SHAMT_W),
            .BASE(BASE), .NLVL(NLVL), .REGISTERED(REGD)
        ) u_stage (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .i_vld (w_vld[g]),
            .o_rdy (w_rdy[g]),
            .i_op  (w_op[g]),
            .i_sh  (w_sh[g]),
            .i_sgn (w_sgn[g]),
            .i_dat (w_dat[g]),
            .i_tag (w_tag[g]),
            .o_vld (w_vld[g+1]),
            .i_rdy (w_rdy[g+1]),
            .o_op  (w_op[g+1]),
            .o_sh  (w_sh[g+1]),
            .o_sgn (w_sgn[g+1]),
            .o_dat (w_dat[g+1]),
            .o_tag (w_tag[g+1])
        );
    end

    assign bus.in_ready_o  = w_rdy[0] && !rst_i;
    assign bus.out_valid_o = w_vld[NGRP] && !rst_i;
    assign bus.data_o      = rst_i ? '0 : w_dat[NGRP];
    assign bus.tag_o       = rst_i ? '0 : w_tag[NGRP];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench: 64-bit L=3 pipe with an expected-result queue, plus an 8-bit L=0 instance.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int L = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_pipe_if #(.WIDTH(64), .TAG_W(4)) ifa ();
    shift_pipe_if #(.WIDTH(8),  .TAG_W(4)) ifb ();

    shift_pipe #(.WIDTH(64), .REG_EVERY(2), .OUT_REG(1'b1), .TAG_W(4))
        u_dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    shift_pipe #(.WIDTH(8), .REG_EVERY(3), .OUT_REG(1'b0), .TAG_W(4))
        u_dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

    typedef struct {
        logic [63:0] d;
        logic [3:0]  t;
        int          c;
        bit          lat;
    } exp_t;
    exp_t q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Every result leaving (or held at) the output must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && ifa.out_valid_o) begin
            if (q.size() == 0) begin
                check("spurious_valid", 64'(ifa.out_valid_o), 64'd0);
            end else begin
                check("data", ifa.data_o, q[0].d);
                check("tag", 64'(ifa.tag_o), 64'(q[0].t));
                if (ifa.out_ready_i) begin
                    if (q[0].lat) check("latency", 64'(cyc - q[0].c), 64'(L));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [5:0] sh, input logic [63:0] d,
                        input logic [3:0] tg, input logic [63:0] exp_d, input bit lat);
        exp_t e;
        bit   done = 1'b0;
        ifa.in_valid_i = 1'b1;
        ifa.op_i       = op;
        ifa.shift_i    = sh;
        ifa.data_i     = d;
        ifa.tag_i      = tg;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ifa.in_ready_o) begin
                e.d = exp_d; e.t = tg; e.c = cyc; e.lat = lat;
                q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 64'(ifa.in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        ifa.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        ifa.in_valid_i = 1'b0; ifa.op_i = '0; ifa.shift_i = '0; ifa.data_i = '0; ifa.tag_i = '0;
        ifa.out_ready_i = 1'b1;
        ifb.in_valid_i = 1'b0; ifb.op_i = '0; ifb.shift_i = '0; ifb.data_i = '0; ifb.tag_i = '0;
        ifb.out_ready_i = 1'b1;

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(ifa.out_valid_o), 64'd0);
        check("rst_in_ready", 64'(ifa.in_ready_o), 64'd0);
        check("rst_data", ifa.data_o, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 64'(ifa.in_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // SLL of all-ones by every amount, back-to-back
        for (int n = 0; n < 64; n++)
            send(SHIFT_SLL, 6'(n), 64'hFFFF_FFFF_FFFF_FFFF, 4'(n), ~64'h0 << n, 1'b1);
        drain();

        // Sign, fill and rotate corners
        send(SHIFT_SRA, 6'd63, 64'h8000_0000_0000_0000, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(SHIFT_SRL, 6'd63, 64'h8000_0000_0000_0000, 4'd2, 64'h0000_0000_0000_0001, 1'b0);
        send(SHIFT_SLL, 6'd63, 64'h8000_0000_0000_0000, 4'd3, 64'h0, 1'b0);
        send(SHIFT_SRA, 6'd62, 64'h4000_0000_0000_0000, 4'd4, 64'h0000_0000_0000_0001, 1'b0);
        send(SHIFT_SRA, 6'd4,  64'hF000_0000_0000_0000, 4'd5, 64'hFF00_0000_0000_0000, 1'b0);
        send(SHIFT_ROL, 6'd63, 64'h1, 4'd6, 64'h8000_0000_0000_0000, 1'b0);
        send(SHIFT_ROR, 6'd1,  64'h1, 4'd7, 64'h8000_0000_0000_0000, 1'b0);
        send(SHIFT_ROL, 6'd0,  64'h1, 4'd8, 64'h1, 1'b0);
        send(SHIFT_ROR, 6'd4,  64'h0123_4567_89AB_CDEF, 4'd9,  64'hF012_3456_789A_BCDE, 1'b0);
        send(SHIFT_ROL, 6'd8,  64'h0123_4567_89AB_CDEF, 4'd10, 64'h2345_6789_ABCD_EF01, 1'b0);
        send(SHIFT_SRA, 6'd0,  64'h8123_0000_0000_0000, 4'd11, 64'h8123_0000_0000_0000, 1'b0);
        send(3'd5, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4'd12, 64'h0, 1'b0);
        send(3'd7, 6'd0, 64'hDEAD_BEEF_0000_0001, 4'd13, 64'h0, 1'b0);
        drain();

        // Mid-stream stall of 6 cycles while tags 0..15 stream in
        fork
            begin
                for (int t = 0; t < 16; t++)
                    send(SHIFT_SLL, 6'd4, 64'(t), 4'(t), 64'(t) << 4, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                ifa.out_ready_i = 1'b0;
                repeat (4) @(negedge clk);
                check("stall_in_ready", 64'(ifa.in_ready_o), 64'd0);
                check("stall_out_valid", 64'(ifa.out_valid_o), 64'd1);
                @(posedge clk);
                @(posedge clk);
                #1;
                ifa.out_ready_i = 1'b1;
            end
        join
        drain();

        // Reset with three ops held in flight
        ifa.out_ready_i = 1'b0;
        send(SHIFT_SLL, 6'd1, 64'h1, 4'd1, 64'h2, 1'b0);
        send(SHIFT_SLL, 6'd2, 64'h1, 4'd2, 64'h4, 1'b0);
        send(SHIFT_SLL, 6'd3, 64'h1, 4'd3, 64'h8, 1'b0);
        rst = 1'b1;
        q.delete();
        ifa.in_valid_i = 1'b1;
        ifa.op_i = SHIFT_SLL; ifa.shift_i = 6'd5; ifa.data_i = 64'h3; ifa.tag_i = 4'd9;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(ifa.out_valid_o), 64'd0);
        check("mid_rst_data", ifa.data_o, 64'd0);
        check("mid_rst_tag", 64'(ifa.tag_o), 64'd0);
        check("mid_rst_in_ready", 64'(ifa.in_ready_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifa.in_valid_i = 1'b0;
        ifa.out_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(SHIFT_SRL, 6'd8, 64'hAB00, 4'd14, 64'hAB, 1'b1);
        drain();

        // Combinational L=0 instance
        ifb.in_valid_i = 1'b1;
        ifb.op_i = SHIFT_SRA; ifb.shift_i = 3'd7; ifb.data_i = 8'h80; ifb.tag_i = 4'd5;
        #1;
        check("l0_sra_data", 64'(ifb.data_o), 64'hFF);
        check("l0_valid", 64'(ifb.out_valid_o), 64'd1);
        check("l0_tag", 64'(ifb.tag_o), 64'd5);
        check("l0_in_ready_hi", 64'(ifb.in_ready_o), 64'd1);
        ifb.out_ready_i = 1'b0;
        ifb.op_i = 3'd7; ifb.shift_i = 3'd2; ifb.data_i = 8'hA5; ifb.tag_i = 4'd9;
        #1;
        check("l0_in_ready_lo", 64'(ifb.in_ready_o), 64'd0);
        check("l0_undef_data", 64'(ifb.data_o), 64'd0);
        check("l0_undef_tag", 64'(ifb.tag_o), 64'd9);
        ifb.out_ready_i = 1'b1;
        ifb.op_i = SHIFT_ROR; ifb.shift_i = 3'd1; ifb.data_i = 8'h01; ifb.tag_i = 4'd3;
        #1;
        check("l0_ror_data", 64'(ifb.data_o), 64'h80);
        ifb.op_i = SHIFT_SLL; ifb.shift_i = 3'd1; ifb.data_i = 8'h81;
        #1;
        check("l0_sll_data", 64'(ifb.data_o), 64'h02);
        ifb.in_valid_i = 1'b0;
        #1;
        check("l0_valid_lo", 64'(ifb.out_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter. Generalises the fixed 64-bit left shifter to any power-of-two width.
- Supports five operations: SLL, SRL, SRA, ROL, ROR.
- Pipeline depth is configurable, and the block uses a valid/ready handshake with per-stage bubble collapsing.
- Sits in datapath blocks (ALU, normaliser, bit-field extract) as a streaming shift unit. A sideband tag travels with each operation.

Parameters:
- WIDTH, 64: data width. Power of two, at least 2.
- REG_EVERY, 2: number of mux levels between pipeline registers. Range 1..SHAMT_W.
- OUT_REG, 1'b1: register the final mux group; 0 leaves it combinational.
- TAG_W, 4: sideband tag width. At least 1.
- Derived SHAMT_W = $clog2(WIDTH), NGRP = ceil(SHAMT_W/REG_EVERY), L = NGRP-1+OUT_REG (latency in cycles).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  input operation valid
- in_ready_o  out  1  block accepts the input this cycle
- op_i  in  3  operation, shift_pkg::shift_op_t
- shift_i  in  SHAMT_W  shift/rotate amount, 0..WIDTH-1
- data_i  in  WIDTH  operand
- tag_i  in  TAG_W  sideband, returned unchanged
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts the result
- data_o  out  WIDTH  result
- tag_o  out  TAG_W  tag of the result

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Transfer rule: a transfer happens on a rising edge where valid and ready are both high, on either side.
- Mux levels: level k (k=0..SHAMT_W-1) moves the data by 2^k when shift_i[k] is set. Levels run in ascending k and are split into NGRP groups of REG_EVERY; the last group may be shorter. A register stage follows every group except the last, which is registered only if OUT_REG. Each stage carries valid, op, remaining amount bits, partial data and tag.
- Operation semantics:
  - SLL: fills zeros from the LSB.
  - SRL: fills zeros from the MSB.
  - SRA: fills with the original data_i[WIDTH-1]. The sign bit is captured at input and carried with the stage.
  - ROL/ROR: rotate modulo WIDTH.
  - shift_i=0: returns data_i for every op.
  - Undefined op codes (5..7): result 0, transfer still completes, tag preserved.
- Stage advance: stage s loads when it is empty or its content leaves in the same cycle. stage_ready[s] = !valid[s] || stage_ready[s+1], where the last stage's ready is out_ready_i. Bubbles collapse, and up to L operations are in flight.
- Ready timing: in_ready_o = stage_ready[0]. This is combinational from out_ready_i through the valid chain; accepted.
- Throughput: 1 op/clock while out_ready_i=1. Latency from input transfer to out_valid_o is exactly L cycles when there is no stall.
- Stall hold: while out_valid_o && !out_ready_i, data_o and tag_o are held stable. Ordering is strictly FIFO, with no loss or duplication.
- L=0 case: fully combinational. out_valid_o=in_valid_i, in_ready_o=out_ready_i, data_o=f(op_i,shift_i,data_i), tag_o=tag_i.
- Reset, while rst_i is high:
  - All stage registers are cleared: valid=0, data=0, tag=0, op=SLL.
  - out_valid_o=0, data_o=0, tag_o=0.
  - in_ready_o=0, and inputs are ignored.
  - In-flight operations are dropped.
  - First acceptance is on the first edge after rst_i falls.
- Simultaneous events: input and output transfers in the same cycle with a full pipe are legal; occupancy stays the same.
- Out-of-range amounts: impossible by construction, since shift_i is SHAMT_W bits and therefore always modulo WIDTH.

Decomposition:
- Package shift_pkg:
  - shift_op_t enum: SHIFT_SLL=0, SHIFT_SRL=1, SHIFT_SRA=2, SHIFT_ROL=3, SHIFT_ROR=4.
  - Helper function for the number of register stages.
- Sub-module shift_stage: REG_EVERY mux levels plus an optional register with valid/ready. Parameters are the base level index, level count and a REGISTERED flag.
- shift_pipe instantiates NGRP shift_stage copies in a generate loop.

Test Plan (WIDTH=64, REG_EVERY=2, OUT_REG=1, L=3 unless stated):
1. SLL, data_i=64'hFFFF_FFFF_FFFF_FFFF, shift_i=0..63 back-to-back, out_ready_i=1 -> data_o = ~64'h0<<n exactly 3 cycles after each input. out_valid_o is continuous and tag_o matches each input.
2. data_i=64'h8000_0000_0000_0000, shift_i=63 -> SRA gives 64'hFFFF_FFFF_FFFF_FFFF, SRL gives 64'h1, SLL gives 0.
3. data_i=64'h1 -> ROL with shift_i=63 gives 64'h8000_0000_0000_0000. ROR with shift_i=1 gives 64'h8000_0000_0000_0000. ROL with shift_i=0 gives 64'h1.
4. Stream tags 0..15 and hold out_ready_i=0 for 6 cycles mid-stream -> in_ready_o drops once 3 ops are held. data_o and tag_o stay stable while stalled, and tags 0..15 come out in order with no duplicates.
5. rst_i asserted for 2 cycles with 3 ops in flight -> on the next edge out_valid_o=0, data_o=0, tag_o=0, in_ready_o=0. After release no stale results appear, and a new op gives its result after 3 cycles.
6. WIDTH=8, REG_EVERY=3, OUT_REG=0 (L=0) -> SRA of 8'h80 by 7 gives 8'hFF in the same cycle. in_ready_o follows out_ready_i, and op code 7 returns 0 with the tag preserved.
